// File: rtl/shift_sequencer_pkg.sv
// +-----------------------------------------------------------------+
// | shift_sequencer_pkg : shared state encoding and line constants  |
// | Revision 1.0 - initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

package shift_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic IDLE_LEVEL = 1'b1;

   // Widest legal word is 32 bits; narrower words are zero-extended.
   function automatic logic even_parity(input logic [31:0] word);
      return ^word;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_bit_counter.sv
// +-----------------------------------------------------------------+
// | bit_counter : clog2(n) bit counter, terminal-count flag at n-1  |
// | Revision 1.0 - initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

module bit_counter #(
   parameter int n = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam int              CW   = $clog2(n);
   localparam logic [CW-1:0]   LAST = CW'(n - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Wraps at n-1 so the count can never reach n.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// +-----------------------------------------------------------------+
// | shift_sequencer : LSB-first parallel-to-serial frame sequencer  |
// | Optional parity bit enabled by SHIFT_SEQUENCER_PARITY_EN        |
// | Revision 1.0 - initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none

module shift_sequencer
   import shift_sequencer_pkg::*;
#(
   parameter int n = 8
) (
   input  logic         Clock,
   input  logic         Reset,
   input  logic         Start,
   input  logic [n-1:0] Data,
   input  logic         w,
   output logic         Sout,
   output logic         Valid,
   output logic         Busy,
   output logic         Done,
   output logic [n-1:0] Q
);

   state_e       state_q, state_d;
   logic [n-1:0] q_q, q_d;
   logic         par_q, par_d;
   logic         sout_q, sout_d;
   logic         valid_q, valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic         cnt_clear;
   logic         cnt_en;
   logic         cnt_tc;

   bit_counter #(
      .n (n)
   ) u_bit_counter (
      .clk    (Clock),
      .rst    (Reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .tc     (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      q_d       = q_q;
      par_d     = par_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d   = SHIFT;
               q_d       = Data;
               par_d     = even_parity(32'(Data));
               cnt_clear = 1'b1;
            end
         end
         SHIFT: begin
            q_d    = {w, q_q[n-1:1]};
            cnt_en = 1'b1;
            if (cnt_tc) begin
`ifdef SHIFT_SEQUENCER_PARITY_EN
               state_d = PARITY;
`else
               state_d = DONE;
`endif
            end
         end
         PARITY:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they leave the flops
      // aligned with the state they describe.
      sout_d  = IDLE_LEVEL;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         SHIFT: begin
            sout_d  = q_d[0];
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         PARITY: begin
            sout_d  = par_d;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         q_q     <= '0;
         par_q   <= 1'b0;
         sout_q  <= IDLE_LEVEL;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         par_q   <= par_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign Sout  = sout_q;
   assign Valid = valid_q;
   assign Busy  = busy_q;
   assign Done  = done_q;
   assign Q     = q_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// +-----------------------------------------------------------------+
// | tb_shift_sequencer : scoreboard bench for n=8 and n=2 instances |
// | Revision 1.0 - initial release                                  |
// +-----------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_shift_sequencer;

`ifdef SHIFT_SEQUENCER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       st8 = 1'b0, w8 = 1'b0;
   logic [7:0] d8  = '0;
   logic       so8, v8, b8, dn8;
   logic [7:0] q8;
   logic       st2 = 1'b0, w2 = 1'b0;
   logic [1:0] d2  = '0;
   logic       so2, v2, b2, dn2;
   logic [1:0] q2;

   shift_sequencer #(.n(8)) dut8 (
      .Clock(clk), .Reset(rst), .Start(st8), .Data(d8), .w(w8),
      .Sout(so8), .Valid(v8), .Busy(b8), .Done(dn8), .Q(q8));

   shift_sequencer #(.n(2)) dut2 (
      .Clock(clk), .Reset(rst), .Start(st2), .Data(d2), .w(w2),
      .Sout(so2), .Valid(v2), .Busy(b2), .Done(dn2), .Q(q2));

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   bit         mon_en = 1'b0;
   bit         expq[2][$];
   logic [7:0] expdone[2][$];
   int         dcyc[2][$];
   int         vcnt[2];
   int         done_cnt[2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon(int id, logic v, logic s, logic b, logic d, logic [7:0] q, int flen);
      chk($sformatf("busy_vs_valid%0d", id), b, v);
      if (!v) chk($sformatf("sout_idle_level%0d", id), s, 1);
      if (v) begin
         chk($sformatf("valid_expected%0d", id), expq[id].size() > 0, 1);
         if (expq[id].size() > 0) chk($sformatf("sout_bit%0d", id), s, expq[id].pop_front());
         vcnt[id]++;
      end
      if (d) begin
         chk($sformatf("done_without_valid%0d", id), v, 0);
         chk($sformatf("done_expected%0d", id), expdone[id].size() > 0, 1);
         if (expdone[id].size() > 0) chk($sformatf("q_at_done%0d", id), q, expdone[id].pop_front());
         chk($sformatf("frame_valid_cycles%0d", id), vcnt[id], flen);
         done_cnt[id]++;
         dcyc[id].push_back(cyc);
      end
      if (!v && !d) vcnt[id] = 0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, v8, so8, b8, dn8, q8, 8 + PAR);
         mon(1, v2, so2, b2, dn2, {6'b0, q2}, 2 + PAR);
      end
   end

   task automatic push8(logic [7:0] d, logic p, logic [7:0] qd);
      for (int i = 0; i < 8; i++) expq[0].push_back(d[i]);
      if (PAR == 1) expq[0].push_back(p);
      expdone[0].push_back(qd);
   endtask

   task automatic push2(logic [1:0] d, logic p, logic [1:0] qd);
      for (int i = 0; i < 2; i++) expq[1].push_back(d[i]);
      if (PAR == 1) expq[1].push_back(p);
      expdone[1].push_back({6'b0, qd});
   endtask

   // Start accepted at edge k; bit 0 must be on Sout during cycle k+1.
   task automatic pulse8(logic [7:0] d, logic wb);
      @(negedge clk); d8 = d; w8 = wb; st8 = 1'b1;
      @(negedge clk); st8 = 1'b0;
      chk("latency_valid8", v8, 1);
      chk("latency_bit0_8", so8, d[0]);
   endtask

   task automatic pulse2(logic [1:0] d, logic wb);
      @(negedge clk); d2 = d; w2 = wb; st2 = 1'b1;
      @(negedge clk); st2 = 1'b0;
      chk("latency_valid2", v2, 1);
      chk("latency_bit0_2", so2, d[0]);
   endtask

   task automatic wait_done(int id, int target, int budget);
      int k = 0;
      while (done_cnt[id] < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk($sformatf("done_seen%0d", id), done_cnt[id] >= target, 1);
   endtask

   task automatic check_held(int id, int base, int period);
      chk($sformatf("held_done_records%0d", id), dcyc[id].size(), base + 3);
      if (dcyc[id].size() >= base + 3) begin
         chk($sformatf("held_period_a%0d", id), dcyc[id][base+1] - dcyc[id][base], period);
         chk($sformatf("held_period_b%0d", id), dcyc[id][base+2] - dcyc[id][base+1], period);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int seen;
      int k;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_sout8", so8, 1);
      chk("reset_valid8", v8, 0);
      chk("reset_busy8", b8, 0);
      chk("reset_done8", dn8, 0);
      chk("reset_q8", q8, 8'h00);
      chk("reset_q2", q2, 2'b00);
      mon_en = 1'b1;
      rst = 1'b0;

      push8(8'hA5, 1'b0, 8'h00); pulse8(8'hA5, 1'b0); wait_done(0, 1, 30);
      push8(8'h01, 1'b1, 8'hFF); pulse8(8'h01, 1'b1); wait_done(0, 2, 30);
      push8(8'h07, 1'b1, 8'h00); pulse8(8'h07, 1'b0); wait_done(0, 3, 30);
      push8(8'h03, 1'b0, 8'h00); pulse8(8'h03, 1'b0); wait_done(0, 4, 30);

      // Start re-pulsed mid-frame with different data must be ignored.
      push8(8'h3C, 1'b0, 8'h00); pulse8(8'h3C, 1'b0);
      repeat (2) @(negedge clk);
      d8 = 8'hFF; st8 = 1'b1;
      @(negedge clk); st8 = 1'b0;
      wait_done(0, 5, 30);
      repeat (12) @(negedge clk);
      chk("single_done_on_repulse", done_cnt[0], 5);
      chk("queue_drained_repulse", expq[0].size(), 0);

      // Reset while bit 3 of 8'h5A is on the line aborts without Done.
      for (int i = 0; i < 4; i++) expq[0].push_back(i[0] ? 1'b1 : 1'b0);
      pulse8(8'h5A, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_sout", so8, 1);
      chk("abort_busy", b8, 0);
      chk("abort_valid", v8, 0);
      chk("abort_done", dn8, 0);
      chk("abort_q", q8, 8'h00);
      repeat (12) @(negedge clk);
      chk("no_done_after_abort", done_cnt[0], 5);
      chk("queue_drained_abort", expq[0].size(), 0);
      push8(8'hA5, 1'b0, 8'h00); pulse8(8'hA5, 1'b0); wait_done(0, 6, 30);

      // n=2 single frame with fill 1: Q ends at 2'b11.
      push2(2'b10, 1'b1, 2'b11); pulse2(2'b10, 1'b1); wait_done(1, 1, 20);

      // Start held high across three back-to-back frames, n=8.
      base = dcyc[0].size();
      for (int f = 0; f < 3; f++) push8(8'hFF, 1'b0, 8'h00);
      @(negedge clk); d8 = 8'hFF; w8 = 1'b0; st8 = 1'b1;
      seen = 0; k = 0;
      while (seen < 3 && k < 100) begin
         @(negedge clk); k++;
         if (dn8) seen++;
      end
      st8 = 1'b0;
      chk("held_frames8", seen, 3);
      repeat (4) @(negedge clk);
      check_held(0, base, 8 + 2 + PAR);

      // Same for n=2.
      base = dcyc[1].size();
      for (int f = 0; f < 3; f++) push2(2'b11, 1'b0, 2'b00);
      @(negedge clk); d2 = 2'b11; w2 = 1'b0; st2 = 1'b1;
      seen = 0; k = 0;
      while (seen < 3 && k < 60) begin
         @(negedge clk); k++;
         if (dn2) seen++;
      end
      st2 = 1'b0;
      chk("held_frames2", seen, 3);
      repeat (4) @(negedge clk);
      check_held(1, base, 2 + 2 + PAR);

      repeat (12) @(negedge clk);
      chk("final_bits_empty8", expq[0].size(), 0);
      chk("final_bits_empty2", expq[1].size(), 0);
      chk("final_done_empty8", expdone[0].size(), 0);
      chk("final_done_empty2", expdone[1].size(), 0);
      chk("total_done8", done_cnt[0], 9);
      chk("total_done2", done_cnt[1], 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter n, default 8, data word width in bits; legal range 2..32.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-004 Start  input  1  request to transmit Data; sampled only in IDLE.
REQ-005 Data  input  n  parallel word; captured on the Start-accepting edge.
REQ-006 w  input  1  fill bit shifted into the MSB on every shift.
REQ-007 Sout  output  1  serial output, LSB first.
REQ-008 Valid  output  1  high while Sout carries a data or parity bit.
REQ-009 Busy  output  1  high in SHIFT and PARITY states.
REQ-010 Done  output  1  one-cycle pulse after the last bit.
REQ-011 Q  output  n  current shift-register contents.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, PARITY and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-013 IDLE: Sout=1, Valid=0, Busy=0, Done=0; Start=1 at an edge SHALL load Q<=Data, clear count and enter SHIFT.
REQ-014 SHIFT: Sout=Q[0], Valid=1; each edge SHALL perform Q<={w,Q[n-1:1]} and count<=count+1.
REQ-015 SHIFT exit: on the edge where count==n-1, go to PARITY if PARITY_EN is defined, else DONE.
REQ-016 Latency: Start accepted at edge k, so data bit i is on Sout during cycle k+1+i (i=0..n-1).
REQ-017 PARITY: Sout=even parity (XOR) of the captured word, Valid=1, Q held; next edge SHALL go to DONE.
REQ-018 DONE: Done=1 for exactly one cycle, Busy=0, Valid=0, Sout=1; next edge SHALL go to IDLE.
REQ-019 Start asserted in SHIFT, PARITY or DONE SHALL be ignored, with no queuing.
REQ-020 Start held high continuously SHALL restart on the first IDLE edge after DONE, giving one idle cycle between words.
REQ-021 Count width SHALL be clog2(n); count SHALL never exceed n-1.
REQ-022 The parity accumulator SHALL be computed from the captured word, not from Q after fill bits enter.

Reset
REQ-023 Reset=1 SHALL force IDLE, Q=0, count=0, parity=0, Sout=1, Valid=0, Busy=0, Done=0 on the next edge.
REQ-024 Reset SHALL take priority over Start and abort any transfer mid-word with no Done pulse.

Configuration
REQ-025 Macro SHIFT_SEQUENCER_PARITY_EN: when defined, the PARITY state and parity bit SHALL be present, and a frame is n+1 Valid cycles.
REQ-026 Without SHIFT_SEQUENCER_PARITY_EN: PARITY SHALL be unreachable and removed by synthesis, and a frame is n Valid cycles.

Structure
REQ-027 Package shift_sequencer_pkg SHALL hold the state enum (IDLE, SHIFT, PARITY, DONE) and the idle-line level constant (1).
REQ-028 Sub-module bit_counter SHALL contain the parameterised clog2(n) counter with clear, enable and a terminal-count flag at n-1.

Verification
REQ-029 n=8, Data=8'hA5, w=0, Start pulse: Sout LSB-first = 1,0,1,0,0,1,0,1 on 8 Valid cycles, then Done, and Q=8'h00 at Done.
REQ-030 n=8, Data=8'h01, w=1: Q=8'hFF at Done, and Sout shows 1 then seven 0s.
REQ-031 PARITY_EN, Data=8'h07: ninth Valid bit = 1; Data=8'h03: ninth Valid bit = 0.
REQ-032 Start re-pulsed during SHIFT with different Data: output stream unchanged and exactly one Done.
REQ-033 Reset asserted at the 4th data bit: next cycle is IDLE with Sout=1, Busy=0, no Done; a subsequent Start transmits normally.
REQ-034 Start held high with Data=8'hFF over three frames: each frame is 8 (or 9) Valid cycles, Done, then one idle cycle; repeat for n=2.
